pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the in-order RISC-V pipeline.
- Drives the flush and stall controls of the IF/ID, ID/EX and EX/MEM pipeline registers, the PC redirect, and the NOP injection value used as their flush load value.
- Resolves load-use hazards, taken branches, traps and multi-cycle EX operations with a small FSM.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the in-order pipeline: load-use, branch, trap and
// multi-cycle EX hazards, plus saturating stall/redirect performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter logic [WORD_WIDTH-1:0] NOP_INST = WORD_WIDTH'(32'h00000013),
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic                      id_rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic [WORD_WIDTH-1:0]     ex_branch_target,
  input  logic                      ex_mc_start,
  input  logic                      mc_done,
  input  logic                      trap_req,
  input  logic [WORD_WIDTH-1:0]     trap_vector,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_stall,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      pc_redirect,
  output logic [WORD_WIDTH-1:0]     pc_redirect_addr,
  output logic                      trap_taken,
  output logic [WORD_WIDTH-1:0]     zero_point,
  output logic [PERF_WIDTH-1:0]     stall_cnt,
  output logic [PERF_WIDTH-1:0]     flush_cnt,
  output logic [1:0]                state
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t             cur_state;
  state_t             nxt_state;
  logic [CNT_W-1:0]   flush_left;
  logic [CNT_W-1:0]   flush_left_nxt;
  logic               load_use;

  assign zero_point = NOP_INST;
  assign state      = cur_state;

  assign load_use = ex_mem_read && (ex_rd_addr != '0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  // Next state and same-cycle control outputs
  always_comb begin
    nxt_state        = cur_state;
    flush_left_nxt   = flush_left;
    pc_stall         = 1'b0;
    if_id_stall      = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_stall      = 1'b0;
    id_ex_flush      = 1'b0;
    ex_mem_flush     = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_addr = '0;
    trap_taken       = 1'b0;

    case (cur_state)
      RUN, FLUSH: begin
        if (trap_req) begin
          pc_redirect      = 1'b1;
          pc_redirect_addr = trap_vector;
          trap_taken       = 1'b1;
          if_id_flush      = 1'b1;
          id_ex_flush      = 1'b1;
          ex_mem_flush     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            nxt_state      = FLUSH;
            flush_left_nxt = CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            nxt_state      = RUN;
          end
        end else if (cur_state == FLUSH) begin
          if_id_flush    = 1'b1;
          id_ex_flush    = 1'b1;
          flush_left_nxt = flush_left - CNT_W'(1);
          if (flush_left == CNT_W'(1)) nxt_state = RUN;
        end else if (ex_branch_taken) begin
          pc_redirect      = 1'b1;
          pc_redirect_addr = ex_branch_target;
          if_id_flush      = 1'b1;
          id_ex_flush      = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            nxt_state      = FLUSH;
            flush_left_nxt = CNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (ex_mc_start) begin
          // A result that is ready in the start cycle needs no wait at all
          if (!mc_done) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            nxt_state    = MC_WAIT;
          end
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      MC_WAIT: begin
        if (!mc_done) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_flush = 1'b1;
        end else begin
          nxt_state = RUN;
        end
      end
      default: nxt_state = RUN;
    endcase

    if (rst) begin
      pc_stall         = 1'b0;
      if_id_stall      = 1'b0;
      if_id_flush      = 1'b0;
      id_ex_stall      = 1'b0;
      id_ex_flush      = 1'b0;
      ex_mem_flush     = 1'b0;
      pc_redirect      = 1'b0;
      pc_redirect_addr = '0;
      trap_taken       = 1'b0;
    end
  end

  // State, countdown and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= RUN;
      flush_left <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      cur_state  <= nxt_state;
      flush_left <= flush_left_nxt;
      if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_WIDTH'(1);
      if (pc_redirect && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (1-cycle flush / 32-bit counters and
// 3-cycle flush / 4-bit counters) checked every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        pc_stall;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_flush;
    logic        ex_mem_flush;
    logic        pc_redirect;
    logic        trap_taken;
    logic [31:0] addr;
  } ctl_t;

  typedef struct {
    int     mode;   // 0 running, 1 waiting on multi-cycle op, 2 holding flush
    int     left;   // flush cycles still to hold
    longint scnt;
    longint fcnt;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, mem_read, br, mc_start, mc_done, trap;
  logic [31:0] br_tgt, trap_vec;

  logic        a_ps, a_ifs, a_iff, a_ies, a_ief, a_emf, a_red, a_tt;
  logic [31:0] a_addr, a_zero, a_scnt, a_fcnt;
  logic [1:0]  a_state;
  logic        b_ps, b_ifs, b_iff, b_ies, b_ief, b_emf, b_red, b_tt;
  logic [31:0] b_addr, b_zero;
  logic [3:0]  b_scnt, b_fcnt;
  logic [1:0]  b_state;
  ctl_t        a_got, b_got;

  int   checks = 0;
  int   errors = 0;
  mdl_t ma, mb;
  ctl_t la, lb;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .PERF_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs1_addr(rs1), .id_rs1_used(rs1_used), .id_rs2_addr(rs2), .id_rs2_used(rs2_used),
    .ex_rd_addr(rd), .ex_mem_read(mem_read), .ex_branch_taken(br), .ex_branch_target(br_tgt),
    .ex_mc_start(mc_start), .mc_done(mc_done), .trap_req(trap), .trap_vector(trap_vec),
    .pc_stall(a_ps), .if_id_stall(a_ifs), .if_id_flush(a_iff), .id_ex_stall(a_ies),
    .id_ex_flush(a_ief), .ex_mem_flush(a_emf), .pc_redirect(a_red), .pc_redirect_addr(a_addr),
    .trap_taken(a_tt), .zero_point(a_zero), .stall_cnt(a_scnt), .flush_cnt(a_fcnt),
    .state(a_state));

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .PERF_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1_addr(rs1), .id_rs1_used(rs1_used), .id_rs2_addr(rs2), .id_rs2_used(rs2_used),
    .ex_rd_addr(rd), .ex_mem_read(mem_read), .ex_branch_taken(br), .ex_branch_target(br_tgt),
    .ex_mc_start(mc_start), .mc_done(mc_done), .trap_req(trap), .trap_vector(trap_vec),
    .pc_stall(b_ps), .if_id_stall(b_ifs), .if_id_flush(b_iff), .id_ex_stall(b_ies),
    .id_ex_flush(b_ief), .ex_mem_flush(b_emf), .pc_redirect(b_red), .pc_redirect_addr(b_addr),
    .trap_taken(b_tt), .zero_point(b_zero), .stall_cnt(b_scnt), .flush_cnt(b_fcnt),
    .state(b_state));

  assign a_got = {a_ps, a_ifs, a_iff, a_ies, a_ief, a_emf, a_red, a_tt, a_addr};
  assign b_got = {b_ps, b_ifs, b_iff, b_ies, b_ief, b_emf, b_red, b_tt, b_addr};

  // Required controls for the current cycle, from the model's mode and the inputs
  function automatic ctl_t predict(mdl_t m);
    ctl_t e = '0;
    bit   hazard;
    hazard = mem_read && rd != 0 &&
             ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
    if (rst) return e;
    if (m.mode == 1) begin
      if (!mc_done) {e.pc_stall, e.if_id_stall, e.id_ex_stall, e.ex_mem_flush} = 4'b1111;
    end else if (trap) begin
      e.pc_redirect = 1; e.addr = trap_vec; e.trap_taken = 1;
      e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_flush = 1;
    end else if (m.mode == 2) begin
      e.if_id_flush = 1; e.id_ex_flush = 1;
    end else if (br) begin
      e.pc_redirect = 1; e.addr = br_tgt; e.if_id_flush = 1; e.id_ex_flush = 1;
    end else if (mc_start) begin
      if (!mc_done) {e.pc_stall, e.if_id_stall, e.id_ex_stall, e.ex_mem_flush} = 4'b1111;
    end else if (hazard) begin
      e.pc_stall = 1; e.if_id_stall = 1; e.id_ex_flush = 1;
    end
    return e;
  endfunction

  function automatic mdl_t advance(mdl_t m, ctl_t e, int fc, int pw);
    longint lim = (longint'(1) << pw) - 1;
    if (rst) return '{0, 0, 0, 0};
    if (e.pc_stall && m.scnt < lim) m.scnt++;
    if (e.pc_redirect && m.fcnt < lim) m.fcnt++;
    if (m.mode == 1) begin
      if (mc_done) m.mode = 0;
    end else if (e.pc_redirect) begin
      if (fc > 1) begin m.mode = 2; m.left = fc - 1; end
    end else if (m.mode == 2) begin
      m.left--;
      if (m.left == 0) m.mode = 0;
    end else if (mc_start && !mc_done) begin
      m.mode = 1;
    end
    return m;
  endfunction

  task automatic cmp(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_dut(string tag, ctl_t e, mdl_t m, ctl_t g, logic [31:0] zero,
                           logic [1:0] st, logic [63:0] sc, logic [63:0] fcn);
    cmp({tag, ".pc_stall"},     64'(g.pc_stall),     64'(e.pc_stall));
    cmp({tag, ".if_id_stall"},  64'(g.if_id_stall),  64'(e.if_id_stall));
    cmp({tag, ".if_id_flush"},  64'(g.if_id_flush),  64'(e.if_id_flush));
    cmp({tag, ".id_ex_stall"},  64'(g.id_ex_stall),  64'(e.id_ex_stall));
    cmp({tag, ".id_ex_flush"},  64'(g.id_ex_flush),  64'(e.id_ex_flush));
    cmp({tag, ".ex_mem_flush"}, 64'(g.ex_mem_flush), 64'(e.ex_mem_flush));
    cmp({tag, ".pc_redirect"},  64'(g.pc_redirect),  64'(e.pc_redirect));
    cmp({tag, ".trap_taken"},   64'(g.trap_taken),   64'(e.trap_taken));
    cmp({tag, ".redirect_addr"}, 64'(g.addr),        64'(e.addr));
    cmp({tag, ".zero_point"},   64'(zero),           64'h13);
    cmp({tag, ".state"},        64'(st),             64'(m.mode));
    cmp({tag, ".stall_cnt"},    sc,                  64'(m.scnt));
    cmp({tag, ".flush_cnt"},    fcn,                 64'(m.fcnt));
  endtask

  // One cycle: compare mid-cycle, then advance the models at the edge
  task automatic step();
    @(negedge clk);
    la = predict(ma);
    lb = predict(mb);
    check_dut("a", la, ma, a_got, a_zero, a_state, 64'(a_scnt), 64'(a_fcnt));
    check_dut("b", lb, mb, b_got, b_zero, b_state, 64'(b_scnt), 64'(b_fcnt));
    @(posedge clk);
    ma = advance(ma, la, 1, 32);
    mb = advance(mb, lb, 3, 4);
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0; mem_read = 0;
    br = 0; mc_start = 0; mc_done = 0; trap = 0; br_tgt = 0; trap_vec = 0;
  endtask

  task automatic set_load_use(logic [4:0] dest);
    mem_read = 1; rd = dest; rs2_used = 1; rs2 = 5;
  endtask

  initial begin
    idle_inputs();
    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    rst = 1; trap = 1; trap_vec = 32'h200;
    @(posedge clk); #1;

    // Reset holds everything low even with a pending trap
    step(); step();
    cmp("pin_reset_redirect", 64'(la.pc_redirect), 64'h0);
    cmp("pin_reset_state", 64'(a_state), 64'h0);
    cmp("pin_reset_flush_cnt", 64'(a_fcnt), 64'h0);

    rst = 0;
    step();
    cmp("pin_trap_taken", 64'(la.trap_taken), 64'h1);
    cmp("pin_trap_addr", 64'(la.addr), 64'h200);
    cmp("pin_trap_flush_cnt", 64'(a_fcnt), 64'h1);
    cmp("pin_b_trap_state", 64'(b_state), 64'h2);
    trap = 0;
    step(); step();

    // Load-use bubble, then the same with x0 as destination
    set_load_use(5'd5);
    step();
    cmp("pin_lu_pc_stall", 64'(la.pc_stall), 64'h1);
    cmp("pin_lu_id_ex_flush", 64'(la.id_ex_flush), 64'h1);
    cmp("pin_lu_stall_cnt", 64'(a_scnt), 64'h1);
    rd = 0;
    step();
    cmp("pin_lu_x0_stall", 64'(la.pc_stall), 64'h0);

    // Branch beats load-use in the same cycle
    rd = 5; br = 1; br_tgt = 32'h80;
    step();
    cmp("pin_br_redirect", 64'(la.pc_redirect), 64'h1);
    cmp("pin_br_addr", 64'(la.addr), 64'h80);
    cmp("pin_br_pc_stall", 64'(la.pc_stall), 64'h0);
    cmp("pin_br_flush_cnt", 64'(a_fcnt), 64'h2);
    idle_inputs();
    step(); step();

    // Multi-cycle op: 4 stall cycles, a branch pulse in the wait is ignored
    mc_start = 1;
    step();
    cmp("pin_mc_ex_mem_flush", 64'(la.ex_mem_flush), 64'h1);
    cmp("pin_mc_state", 64'(a_state), 64'h1);
    mc_start = 0;
    step();
    br = 1; br_tgt = 32'h44;
    step();
    cmp("pin_mc_br_ignored", 64'(la.pc_redirect), 64'h0);
    br = 0;
    step();
    mc_done = 1;
    step();
    cmp("pin_mc_release", 64'(la.pc_stall), 64'h0);
    cmp("pin_mc_release_state", 64'(a_state), 64'h0);
    cmp("pin_mc_stall_cnt", 64'(a_scnt), 64'h5);
    mc_done = 0;

    // Three-cycle flush with a trap restarting the countdown
    br = 1; br_tgt = 32'h100;
    step();
    cmp("pin_b_br_state", 64'(b_state), 64'h2);
    br = 0;
    step();
    cmp("pin_b_flush_hold", 64'(lb.if_id_flush), 64'h1);
    cmp("pin_b_flush_noredir", 64'(lb.pc_redirect), 64'h0);
    trap = 1; trap_vec = 32'h300;
    step();
    cmp("pin_b_flush_trap", 64'(lb.pc_redirect), 64'h1);
    cmp("pin_b_flush_trap_addr", 64'(lb.addr), 64'h300);
    cmp("pin_b_restart_state", 64'(b_state), 64'h2);
    trap = 0;
    step(); step();
    cmp("pin_b_back_to_run", 64'(b_state), 64'h0);
    cmp("pin_a_flush_cnt", 64'(a_fcnt), 64'h4);

    // Saturation of the 4-bit stall counter
    set_load_use(5'd5);
    repeat (20) step();
    cmp("pin_b_stall_sat", 64'(b_scnt), 64'hf);
    cmp("pin_a_stall_cnt", 64'(a_scnt), 64'd25);
    idle_inputs();

    // Random traffic over small register indices so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(99) == 0);
      rs1      = 5'($urandom_range(3));
      rs2      = 5'($urandom_range(3));
      rd       = 5'($urandom_range(3));
      rs1_used = 1'($urandom);
      rs2_used = 1'($urandom);
      mem_read = ($urandom_range(2) == 0);
      br       = ($urandom_range(7) == 0);
      br_tgt   = $urandom;
      mc_start = ($urandom_range(7) == 0);
      mc_done  = ($urandom_range(3) == 0);
      trap     = ($urandom_range(15) == 0);
      trap_vec = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
